// File: rtl/busy_latency_monitor.sv
// busy_latency_monitor
// Measures each busy window of level_in in clock cycles and queues the per-window
// latency into a small first-word-fall-through FIFO. Also keeps running job count,
// maximum latency and dropped-result count for host performance registers.
module busy_latency_monitor #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned JOB_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             level_in,
    input  logic             clear,
    output logic             lat_valid,
    input  logic             lat_ready,
    output logic [CNT_W-1:0] lat_data,
    output logic             lat_sat,
    output logic [JOB_W-1:0] job_count,
    output logic [CNT_W-1:0] max_lat,
    output logic [JOB_W-1:0] drop_count,
    output logic             active
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_WAIT_LOW = 2'd0,
        S_IDLE     = 2'd1,
        S_MEASURE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [JOB_W-1:0]   r_job;
    logic [CNT_W-1:0]   r_max;
    logic [JOB_W-1:0]   r_drop;
    logic [CNT_W-1:0]   r_mem_data [FIFO_DEPTH];
    logic               r_mem_sat  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [OCC_W-1:0]   r_occ;

    logic               w_close;
    logic               w_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_cnt_sat;

    // Window close, FIFO handshake and push/drop decision
    always_comb begin
        w_close   = (r_state == S_MEASURE) && !level_in;
        w_valid   = (r_occ != '0);
        w_full    = (r_occ == OCC_W'(FIFO_DEPTH));
        w_pop     = w_valid && lat_ready;
        // A full FIFO still takes the result when the head leaves in the same cycle
        w_push    = w_close && (!w_full || w_pop);
        w_drop    = w_close && !w_push;
        w_cnt_sat = (r_cnt == '1);
    end

    // Window FSM and saturating latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_WAIT_LOW;
            r_cnt   <= '0;
        end else if (clear) begin
            r_state <= S_WAIT_LOW;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_WAIT_LOW: begin
                    if (!level_in) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (level_in) begin
                        r_state <= S_MEASURE;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (level_in) begin
                        if (!w_cnt_sat) r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_WAIT_LOW;
            endcase
        end
    end

    // Job count, maximum latency and drop count, updated on every window close
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_job  <= '0;
            r_max  <= '0;
            r_drop <= '0;
        end else if (clear) begin
            r_job  <= '0;
            r_max  <= '0;
            r_drop <= '0;
        end else begin
            if (w_close) begin
                if (r_job != '1) r_job <= r_job + 1'b1;
                if (r_cnt > r_max) r_max <= r_cnt;
            end
            if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
        end
    end

    // Result FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_sat[i]  <= 1'b0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else if (clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wptr] <= r_cnt;
                r_mem_sat[r_wptr]  <= w_cnt_sat;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign lat_valid  = w_valid;
    assign lat_data   = r_mem_data[r_rptr];
    assign lat_sat    = r_mem_sat[r_rptr];
    assign job_count  = r_job;
    assign max_lat    = r_max;
    assign drop_count = r_drop;
    assign active     = (r_state == S_MEASURE);

endmodule
